// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for the single-port DMEM with atomic lock sequences.
// Optional accept/conflict counters are compiled in with DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 64,
    parameter int LOCK_MAX = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       a_cnt,
    output logic [15:0]       b_cnt,
    output logic [15:0]       conf_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              a_acc, b_acc, lock_a, lock_b, timeout, rel;
    logic              en_q, wr_q, own_q, a_rv_q, b_rv_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    // ptr_q = 0 favours A, 1 favours B
    always_comb begin
        lock_a  = state_q == LOCK_A;
        lock_b  = state_q == LOCK_B;
        a_gnt   = a_req && (lock_a || (state_q == ARB && (!b_req || !ptr_q)));
        b_gnt   = b_req && (lock_b || (state_q == ARB && (!a_req || ptr_q)));
        a_acc   = a_req && a_gnt;
        b_acc   = b_req && b_gnt;
        timeout = (lock_a || lock_b) && cnt_q == CW'(LOCK_MAX - 1);
        rel     = timeout || (lock_a && a_acc && !a_lock) || (lock_b && b_acc && !b_lock);
        state_d = state_q == ARB ? (a_acc && a_lock ? LOCK_A : b_acc && b_lock ? LOCK_B : ARB)
                                 : rel ? ARB : state_q;
        cnt_d   = (state_q != ARB && !rel) ? cnt_q + 1'b1 : '0;
        ptr_d   = a_acc ? 1'b1 : b_acc ? 1'b0 : timeout ? lock_a : ptr_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ARB;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            own_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            en_q    <= a_acc || b_acc;
            if (a_acc || b_acc) begin
                wr_q    <= a_acc ? a_wr : b_wr;
                addr_q  <= a_acc ? a_addr : b_addr;
                wdata_q <= a_acc ? a_wdata : b_wdata;
                own_q   <= b_acc;
            end
            a_rv_q <= en_q && !wr_q && !own_q;
            b_rv_q <= en_q && !wr_q && own_q;
            if (en_q && !wr_q)
                rdata_q <= mem_rdata;
        end
    end

    assign mem_en    = en_q;
    assign mem_wr_en = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign a_rvalid  = a_rv_q;
    assign b_rvalid  = b_rv_q;
    assign rdata     = rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] a_cnt_q, b_cnt_q, conf_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            conf_cnt_q <= '0;
        end else begin
            if (a_acc && ~&a_cnt_q)
                a_cnt_q <= a_cnt_q + 1'b1;
            if (b_acc && ~&b_cnt_q)
                b_cnt_q <= b_cnt_q + 1'b1;
            if (a_req && b_req && ~&conf_cnt_q)
                conf_cnt_q <= conf_cnt_q + 1'b1;
        end
    end

    assign a_cnt    = a_cnt_q;
    assign b_cnt    = b_cnt_q;
    assign conf_cnt = conf_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a DMEM model and a transaction-level reference.
module tb_dmem_arbiter;
    localparam int LOCK_MAX = 16;

    logic        CLK, RESET;
    logic        a_req, a_wr, a_lock, b_req, b_wr, b_lock;
    logic [8:0]  a_addr, b_addr, mem_addr;
    logic [63:0] a_wdata, b_wdata, rdata, mem_wdata, mem_rdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_wr_en;

    dmem_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .a_req(a_req), .a_wr(a_wr), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_wr(b_wr), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [63:0] dmem    [512] = '{5: 64'h0123456789ABCDEF, default: 64'h0};
    logic [63:0] ref_mem [512] = '{5: 64'h0123456789ABCDEF, default: 64'h0};

    assign mem_rdata = dmem[mem_addr];
    always @(posedge CLK) if (mem_en && mem_wr_en) dmem[mem_addr] <= mem_wdata;

    typedef struct { int due; logic wr; logic [8:0] addr; logic [63:0] data; } acc_t;
    typedef struct { int due; logic port; logic [63:0] data; } rd_t;
    acc_t acc_q[$];
    rd_t  rd_q[$];

    int   cyc, tests, fails;
    int   owner, age;   // owner: 0 none, 1 A, 2 B
    logic last;         // last port to win: 0 A, 1 B
    bit   armed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic record(input logic p, input logic wr, input logic lk, input logic [8:0] addr, input logic [63:0] d);
        acc_q.push_back('{cyc + 1, wr, addr, d});
        if (wr) ref_mem[addr] = d;
        else rd_q.push_back('{cyc + 2, p, ref_mem[addr]});
        if (owner == 0) begin
            if (lk) begin
                owner = p ? 2 : 1;
                age = 0;
            end
        end else begin
            age++;
            if (!lk || age == LOCK_MAX) owner = 0;
        end
        last = p;
    endtask

    always @(negedge CLK) begin
        logic ea, eb, exp_en, exp_rv;
        acc_t e;
        rd_t  r;
        cyc++;
        if (armed) begin
            ea = a_req && (owner == 1 || (owner == 0 && (!b_req || last)));
            eb = b_req && (owner == 2 || (owner == 0 && (!a_req || !last)));
            check("a_gnt", 64'(a_gnt), 64'(ea));
            check("b_gnt", 64'(b_gnt), 64'(eb));
            exp_en = acc_q.size() != 0 && acc_q[0].due == cyc;
            check("mem_en", 64'(mem_en), 64'(exp_en));
            if (exp_en) begin
                e = acc_q.pop_front();
                check("mem_wr_en", 64'(mem_wr_en), 64'(e.wr));
                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                if (e.wr) check("mem_wdata", mem_wdata, e.data);
            end
            exp_rv = rd_q.size() != 0 && rd_q[0].due == cyc;
            check("a_rvalid", 64'(a_rvalid), 64'(exp_rv && !rd_q[0].port));
            check("b_rvalid", 64'(b_rvalid), 64'(exp_rv && rd_q[0].port));
            if (exp_rv) begin
                r = rd_q.pop_front();
                check("rdata", rdata, r.data);
            end
        end
        if (RESET) begin
            acc_q.delete();
            rd_q.delete();
            owner = 0;
            age = 0;
            last = 1'b1;
            armed = 1'b1;
        end else if (armed) begin
            if (a_req && a_gnt) record(1'b0, a_wr, a_lock, a_addr, a_wdata);
            else if (b_req && b_gnt) record(1'b1, b_wr, b_lock, b_addr, b_wdata);
            else if (owner != 0) begin
                age++;
                if (age == LOCK_MAX) owner = 0;
            end
        end
    end

    task automatic xfer(input logic p, input logic wr, input logic lk, input logic [8:0] addr, input logic [63:0] d);
        int n = 0;
        if (p) begin b_req = 1'b1; b_wr = wr; b_lock = lk; b_addr = addr; b_wdata = d; end
        else   begin a_req = 1'b1; a_wr = wr; a_lock = lk; a_addr = addr; a_wdata = d; end
        do begin
            @(negedge CLK);
            n++;
        end while (!(p ? b_gnt : a_gnt) && n < 200);
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL xfer port %0d: gnt 0 after 200 cycles, expected 1", p);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic p);
        if (p) begin b_req = 1'b0; b_lock = 1'b0; end
        else   begin a_req = 1'b0; a_lock = 1'b0; end
    endtask

    task automatic rand_port(input logic p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                idle(p);
                @(posedge CLK);
                #1;
            end
            xfer(p, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 3) == 0) ? 9'd511 : 9'($urandom_range(0, 15)),
                 {$urandom(), $urandom()});
        end
        idle(p);
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        idle(1'b0);
        idle(1'b1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        RESET = 1'b1;
        {a_req, a_wr, a_lock, b_req, b_wr, b_lock} = '0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset rdata", rdata, 64'h0);
        check("reset mem_wdata", mem_wdata, 64'h0);
        check("reset ctrl", 64'({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_wr_en, mem_addr}), 64'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // single read of preloaded word
        xfer(1'b0, 1'b0, 1'b0, 9'd5, 64'h0);
        idle(1'b0);
        repeat (3) @(posedge CLK);
        #1;

        // contention from reset: grants alternate, one access per cycle
        pulse_reset();
        fork
            begin
                for (int i = 1; i <= 4; i++) xfer(1'b0, 1'b1, 1'b0, 9'(i), {32'hA5A5_0000, 32'(i)});
                idle(1'b0);
            end
            begin
                for (int j = 10; j <= 13; j++) xfer(1'b1, 1'b0, 1'b0, 9'(j), 64'h0);
                idle(1'b1);
            end
        join
        repeat (3) @(posedge CLK);
        #1;

        // B locked sequence while A waits
        fork
            begin
                xfer(1'b1, 1'b0, 1'b1, 9'd20, 64'h0);
                xfer(1'b1, 1'b1, 1'b1, 9'd21, 64'h1111_2222_3333_4444);
                xfer(1'b1, 1'b0, 1'b0, 9'd21, 64'h0);
                idle(1'b1);
            end
            begin
                @(posedge CLK);
                #1;
                xfer(1'b0, 1'b0, 1'b0, 9'd30, 64'h0);
                idle(1'b0);
            end
        join
        repeat (3) @(posedge CLK);
        #1;

        // A locks then goes quiet; B gets in only after the timeout
        fork
            begin
                xfer(1'b0, 1'b0, 1'b1, 9'd40, 64'h0);
                idle(1'b0);
            end
            begin
                @(posedge CLK);
                #1;
                t0 = cyc;
                xfer(1'b1, 1'b0, 1'b0, 9'd41, 64'h0);
                check("lock timeout wait", 64'(cyc - t0), 64'(LOCK_MAX + 1));
                idle(1'b1);
            end
        join
        repeat (3) @(posedge CLK);
        #1;

        // reset during the access cycle of a B read
        xfer(1'b1, 1'b0, 1'b0, 9'd50, 64'h0);
        pulse_reset();
        fork
            begin xfer(1'b0, 1'b0, 1'b0, 9'd60, 64'h0); idle(1'b0); end
            begin xfer(1'b1, 1'b0, 1'b0, 9'd61, 64'h0); idle(1'b1); end
        join
        repeat (3) @(posedge CLK);
        #1;

        // write then immediate read-back at the top address
        xfer(1'b0, 1'b1, 1'b0, 9'd511, 64'hDEADBEEF00000001);
        xfer(1'b0, 1'b0, 1'b0, 9'd511, 64'h0);
        idle(1'b0);
        repeat (3) @(posedge CLK);
        #1;

        fork
            rand_port(1'b0, 300);
            rand_port(1'b1, 300);
        join

        repeat (20) @(negedge CLK);
        check("access queue drained", 64'(acc_q.size()), 64'h0);
        check("read queue drained", 64'(rd_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
